// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared register-file write-port definitions for regfile_wr_arbiter.
// Widths, the NOP register address and write enable constants.
package regfile_wr_arbiter_pkg;
   localparam int REG_DW       = 32;
   localparam int REG_AW       = 5;
   localparam int STARVE_CNT_W = 4;

   localparam logic [REG_AW-1:0] REG_NOP_ADDR = '0;
   localparam logic [REG_DW-1:0] ZERO_WORD    = '0;
   localparam logic              WE_ON        = 1'b1;
   localparam logic              WE_OFF       = 1'b0;
endpackage

// File: rtl/regfile_wr_arbiter_fifo.sv
// regwr_fifo: DEPTH-entry circular queue of pending aux writes, with a
// per-entry valid bit that a younger pipeline write can clear by address.
module regwr_fifo
   import regfile_wr_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              push_vld,
   input  logic [REG_AW-1:0] push_addr,
   input  logic [REG_DW-1:0] push_data,
   input  logic              pop,
   input  logic              squash_en,
   input  logic [REG_AW-1:0] squash_addr,
   output logic              head_valid,
   output logic [REG_AW-1:0] head_addr,
   output logic [REG_DW-1:0] head_data,
   output logic              full,
   output logic              empty,
   output logic              any_valid
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

   logic [PW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH-1:0]  valid_q, valid_d, hit;
   logic [REG_AW-1:0] addr_q [DEPTH];
   logic [REG_AW-1:0] addr_d [DEPTH];
   logic [REG_DW-1:0] data_q [DEPTH];
   logic [REG_DW-1:0] data_d [DEPTH];
   logic [PW-1:0]     wr_idx, rd_idx;

   assign wr_idx = wr_ptr_q[PW-1:0];
   assign rd_idx = rd_ptr_q[PW-1:0];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_match
         assign hit[gi] = squash_en && (addr_q[gi] == squash_addr);
      end
   endgenerate

   // The extra pointer MSB distinguishes full from empty when indices match.
   assign empty      = (wr_ptr_q == rd_ptr_q);
   assign full       = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_idx == rd_idx);
   assign head_valid = !empty && valid_q[rd_idx];
   assign head_addr  = addr_q[rd_idx];
   assign head_data  = data_q[rd_idx];
   assign any_valid  = |valid_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      valid_d  = valid_q & ~hit;
      addr_d   = addr_q;
      data_d   = data_q;
      if (pop) begin
         valid_d[rd_idx] = 1'b0;
         rd_ptr_d        = rd_ptr_q + PTR_ONE;
      end
      if (push) begin
         valid_d[wr_idx] = push_vld;
         addr_d[wr_idx]  = push_addr;
         data_d[wr_idx]  = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         valid_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         valid_q  <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
   end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, aux results queue
// and drain in idle slots. Macro REGWR_STARVE_GUARD_EN enables the stall guard.
module regfile_wr_arbiter
   import regfile_wr_arbiter_pkg::*;
#(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pipe_we,
   input  logic [REG_AW-1:0] pipe_waddr,
   input  logic [REG_DW-1:0] pipe_wdata,
   input  logic              aux_valid,
   output logic              aux_ready,
   input  logic [REG_AW-1:0] aux_waddr,
   input  logic [REG_DW-1:0] aux_wdata,
   output logic              wb_we,
   output logic [REG_AW-1:0] wb_waddr,
   output logic [REG_DW-1:0] wb_wdata,
   output logic              aux_pending,
   output logic              stall_req
);
   logic              pipe_eff, push, push_vld, pop, grant_head;
   logic              head_valid, fifo_full, fifo_empty, any_valid;
   logic [REG_AW-1:0] head_addr;
   logic [REG_DW-1:0] head_data;
   logic              wb_we_q, wb_we_d;
   logic [REG_AW-1:0] wb_waddr_q, wb_waddr_d;
   logic [REG_DW-1:0] wb_wdata_q, wb_wdata_d;
   logic [STARVE_CNT_W-1:0] starve_cnt;

   assign pipe_eff   = pipe_we && (pipe_waddr != REG_NOP_ADDR);
   assign aux_ready  = !rst && !fifo_full;
   assign push       = aux_valid && aux_ready && (aux_waddr != REG_NOP_ADDR);
   // Aux results are older than any concurrent pipe write to the same register.
   assign push_vld   = !(pipe_eff && (pipe_waddr == aux_waddr));
   assign grant_head = !pipe_eff && head_valid;
   assign pop        = grant_head || (!fifo_empty && !head_valid);

   regwr_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .push_vld    (push_vld),
      .push_addr   (aux_waddr),
      .push_data   (aux_wdata),
      .pop         (pop),
      .squash_en   (pipe_eff),
      .squash_addr (pipe_waddr),
      .head_valid  (head_valid),
      .head_addr   (head_addr),
      .head_data   (head_data),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .any_valid   (any_valid)
   );

   always_comb begin
      wb_we_d    = WE_OFF;
      wb_waddr_d = REG_NOP_ADDR;
      wb_wdata_d = ZERO_WORD;
      if (pipe_eff) begin
         wb_we_d    = WE_ON;
         wb_waddr_d = pipe_waddr;
         wb_wdata_d = pipe_wdata;
      end else if (grant_head) begin
         wb_we_d    = WE_ON;
         wb_waddr_d = head_addr;
         wb_wdata_d = head_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_we_q    <= WE_OFF;
         wb_waddr_q <= REG_NOP_ADDR;
         wb_wdata_q <= ZERO_WORD;
      end else begin
         wb_we_q    <= wb_we_d;
         wb_waddr_q <= wb_waddr_d;
         wb_wdata_q <= wb_wdata_d;
      end
   end

`ifdef REGWR_STARVE_GUARD_EN
   logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (grant_head || !any_valid)
         starve_cnt_d = '0;
      else if (pipe_eff && head_valid && (starve_cnt_q != '1))
         starve_cnt_d = starve_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) starve_cnt_q <= '0;
      else     starve_cnt_q <= starve_cnt_d;
   end

   assign starve_cnt = starve_cnt_q;
`else
   // No counter: a constant zero count makes stall_req fold to 0.
   assign starve_cnt = '0;
`endif

   assign stall_req   = (starve_cnt >= STARVE_CNT_W'(STARVE_LIMIT));
   assign wb_we       = wb_we_q;
   assign wb_waddr    = wb_waddr_q;
   assign wb_wdata    = wb_wdata_q;
   assign aux_pending = any_valid;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: queue-level reference model checked
// every cycle plus directed literal expectations (honours REGWR_STARVE_GUARD_EN).
module tb_regfile_wr_arbiter;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pipe_we = 1'b0;
   logic [4:0]  pipe_waddr = '0;
   logic [31:0] pipe_wdata = '0;
   logic        aux_valid = 1'b0;
   logic        aux_ready;
   logic [4:0]  aux_waddr = '0;
   logic [31:0] aux_wdata = '0;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        aux_pending;
   logic        stall_req;

   regfile_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
      .aux_valid(aux_valid), .aux_ready(aux_ready),
      .aux_waddr(aux_waddr), .aux_wdata(aux_wdata),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .aux_pending(aux_pending), .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      bit          ok;
   } ent_t;

   ent_t        mq[$];
   logic        m_we   = 1'b0;
   logic [4:0]  m_addr = '0;
   logic [31:0] m_data = '0;
   int          m_st   = 0;
   logic [36:0] wlog[$];
   logic [36:0] elog[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_any_valid();
      foreach (mq[i]) if (mq[i].ok) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic model_stall();
`ifdef REGWR_STARVE_GUARD_EN
      return (m_st >= LIMIT);
`else
      return 1'b0;
`endif
   endfunction

   // Advance the model across the coming rising edge using this cycle's inputs.
   task automatic model_step();
      bit pe, head_ok, anyv, gh;
      if (rst) begin
         mq.delete();
         m_we = 0; m_addr = '0; m_data = '0; m_st = 0;
         return;
      end
      pe      = pipe_we && (pipe_waddr != 5'd0);
      head_ok = (mq.size() > 0) && mq[0].ok;
      anyv    = model_any_valid();
      gh      = 1'b0;
      if (pe) begin
         m_we = 1; m_addr = pipe_waddr; m_data = pipe_wdata;
         if (mq.size() > 0 && !mq[0].ok) void'(mq.pop_front());
      end else if (head_ok) begin
         m_we = 1; m_addr = mq[0].a; m_data = mq[0].d; gh = 1'b1;
         void'(mq.pop_front());
      end else begin
         m_we = 0; m_addr = '0; m_data = '0;
         if (mq.size() > 0) void'(mq.pop_front());
      end
      if (pe) foreach (mq[i]) if (mq[i].a == pipe_waddr) mq[i].ok = 1'b0;
      if (aux_valid && aux_ready && aux_waddr != 5'd0 && mq.size() < DEPTH) begin
         ent_t e;
         e.a = aux_waddr; e.d = aux_wdata; e.ok = !(pe && pipe_waddr == aux_waddr);
         mq.push_back(e);
      end
      if (gh || !anyv) m_st = 0;
      else if (pe && head_ok && m_st < 15) m_st++;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("wb_we", wb_we, m_we);
         if (m_we) begin
            check("wb_waddr", wb_waddr, m_addr);
            check("wb_wdata", wb_wdata, m_data);
         end
         check("aux_ready", aux_ready, (!rst && mq.size() < DEPTH));
         check("aux_pending", aux_pending, model_any_valid());
         check("stall_req", stall_req, model_stall());
         if (wb_we) wlog.push_back({wb_waddr, wb_wdata});
      end
      model_step();
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                        input logic av, input logic [4:0] aa, input logic [31:0] ad);
      pipe_we = pwe; pipe_waddr = pa; pipe_wdata = pd;
      aux_valid = av; aux_waddr = aa; aux_wdata = ad;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic expw(input logic [4:0] a, input logic [31:0] d);
      elog.push_back({a, d});
   endtask

   task automatic check_log(input string name);
      int n;
      check({name, "_len"}, wlog.size(), elog.size());
      n = (wlog.size() < elog.size()) ? wlog.size() : elog.size();
      for (int i = 0; i < n; i++) check(name, wlog[i], elog[i]);
      wlog.delete();
      elog.delete();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      tick(); tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_wb_we", wb_we, 1'b0);
      check("rst_ready_after", aux_ready, 1'b1);
      check("rst_pending", aux_pending, 1'b0);
      tick();
      check_log("rst_log");

      // Pipe only
      drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
      tick();
      idle();
      @(negedge clk);
      check("s1_we", wb_we, 1'b1);
      check("s1_addr", wb_waddr, 5'd5);
      check("s1_data", wb_wdata, 32'h1234);
      check("s1_pending", aux_pending, 1'b0);
      tick(); tick();
      expw(5'd5, 32'h1234);
      check_log("s1_log");

      // Aux drain in an idle slot, two cycles after acceptance
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA);
      tick();
      idle();
      @(negedge clk);
      check("s2_early_we", wb_we, 1'b0);
      tick();
      @(negedge clk);
      check("s2_we", wb_we, 1'b1);
      check("s2_addr", wb_waddr, 5'd7);
      check("s2_data", wb_wdata, 32'hAA);
      tick(); tick();
      expw(5'd7, 32'hAA);
      check_log("s2_log");

      // Back-pressure and pointer wrap
      for (int rep = 0; rep < 3; rep++) begin
         drive(1'b1, 5'd20, 32'h200 + rep * 3, 1'b1, 5'd3, 32'h30 + rep);
         tick();
         drive(1'b1, 5'd20, 32'h201 + rep * 3, 1'b1, 5'd4, 32'h40 + rep);
         tick();
         drive(1'b1, 5'd20, 32'h202 + rep * 3, 1'b1, 5'd5, 32'h50);
         @(negedge clk);
         check("s3_ready_full", aux_ready, 1'b0);
         tick();
         idle();
         tick(); tick(); tick();
         check("s3_ready_back", aux_ready, 1'b1);
         for (int k = 0; k < 3; k++) expw(5'd20, 32'h200 + rep * 3 + k);
         expw(5'd3, 32'h30 + rep);
         expw(5'd4, 32'h40 + rep);
         check_log("s3_log");
      end

      // WAW squash: queued entry then younger pipe write
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h99);
      tick();
      drive(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'd0);
      tick();
      idle();
      tick(); tick(); tick();
      expw(5'd1, 32'h11);
      expw(5'd9, 32'h55);
      check_log("s4_log");
      // Same-cycle aux and pipe to the same register
      drive(1'b1, 5'd9, 32'h66, 1'b1, 5'd9, 32'h77);
      tick();
      idle();
      tick(); tick(); tick();
      check("s4_pending", aux_pending, 1'b0);
      expw(5'd9, 32'h66);
      check_log("s4b_log");

      // Address 0 handling
      drive(1'b1, 5'd1, 32'h12, 1'b1, 5'd2, 32'h22);
      tick();
      drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
      tick();
      idle();
      @(negedge clk);
      check("s5_we", wb_we, 1'b1);
      check("s5_addr", wb_waddr, 5'd2);
      check("s5_data", wb_wdata, 32'h22);
      tick(); tick();
      expw(5'd1, 32'h12);
      expw(5'd2, 32'h22);
      check_log("s5_log");
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBB);
      @(negedge clk);
      check("s5_zero_ready", aux_ready, 1'b1);
      tick();
      idle();
      @(negedge clk);
      check("s5_zero_pending", aux_pending, 1'b0);
      tick(); tick(); tick();
      check_log("s5b_log");

      // Starvation: continuous pipe writes with one queued aux entry
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 5'd11, 32'h600 + i, (i == 0), 5'd12, 32'hC0);
         tick();
      end
      idle();
      @(negedge clk);
`ifdef REGWR_STARVE_GUARD_EN
      check("s6_stall_high", stall_req, 1'b1);
`else
      check("s6_stall_off", stall_req, 1'b0);
`endif
      tick();
      @(negedge clk);
      check("s6_aux_we", wb_we, 1'b1);
      check("s6_aux_addr", wb_waddr, 5'd12);
      check("s6_stall_low", stall_req, 1'b0);
      tick(); tick();
      for (int i = 0; i < 6; i++) expw(5'd11, 32'h600 + i);
      expw(5'd12, 32'hC0);
      check_log("s6_log");

      // Reset with two entries queued
      drive(1'b1, 5'd13, 32'h700, 1'b1, 5'd14, 32'hE0);
      tick();
      drive(1'b1, 5'd13, 32'h701, 1'b1, 5'd15, 32'hF0);
      tick();
      idle();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      @(negedge clk);
      check("s7_we", wb_we, 1'b0);
      check("s7_addr", wb_waddr, 5'd0);
      check("s7_pending", aux_pending, 1'b0);
      check("s7_stall", stall_req, 1'b0);
      check("s7_ready", aux_ready, 1'b1);
      tick(); tick(); tick(); tick();
      expw(5'd13, 32'h700);
      expw(5'd13, 32'h701);
      check_log("s7_log");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
